// File: rtl/tick_pkg.sv
// Shared encodings for the tic-tac-toe LED board: game states, cell marks,
// and the eight winning lines.
package tick_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    WIN   = 2'd2,
    DRAW  = 2'd3
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_X     = 2'd1;
  localparam logic [1:0] CELL_O     = 2'd2;

  typedef logic [8:0][1:0] board_t;

  localparam int WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Mask of every cell that sits on a line fully owned by mark m.
  function automatic logic [8:0] line_cells(input board_t b, input logic [1:0] m);
    logic [8:0] hit;
    hit = '0;
    for (int l = 0; l < 8; l++) begin
      if (b[WIN_LINES[l][0]] == m && b[WIN_LINES[l][1]] == m &&
          b[WIN_LINES[l][2]] == m) begin
        hit[WIN_LINES[l][0]] = 1'b1;
        hit[WIN_LINES[l][1]] = 1'b1;
        hit[WIN_LINES[l][2]] = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Single-bit rising-edge detector: one-cycle pulse when a level input goes high.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/tick_board_ctrl.sv
// Tic-tac-toe game controller: button-driven cursor/placement, one-cycle win/draw
// check, and a registered 8x8 LED frame with blink overlays.
module tick_board_ctrl
  import tick_pkg::*;
#(
  parameter int BLINK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_place,
  input  logic        btn_new,
  output logic [63:0] frame,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [1:0]  winner
);

  localparam int CW = $clog2(BLINK_DIV);

  logic p_next, p_place, p_new;

  btn_edge u_next  (.clk(clk), .reset(reset), .d(btn_next),  .pulse(p_next));
  btn_edge u_place (.clk(clk), .reset(reset), .d(btn_place), .pulse(p_place));
  btn_edge u_new   (.clk(clk), .reset(reset), .d(btn_new),   .pulse(p_new));

  state_t        state, state_n;
  board_t        cells, cells_n;
  logic [3:0]    cursor, cursor_n;
  logic          turn_n;
  logic [1:0]    winner_n;
  logic [CW-1:0] blink_cnt;
  logic          blink;
  logic [1:0]    mover;
  logic [8:0]    mover_mask;
  logic          full;
  logic [63:0]   img;
  logic          on4, diag;

  // turn only changes on a non-winning CHECK, so in WIN the mover is the winner
  assign mover      = turn ? CELL_O : CELL_X;
  assign mover_mask = line_cells(cells, mover);

  always_comb begin
    full = 1'b1;
    for (int k = 0; k < 9; k++)
      if (cells[k] == CELL_EMPTY) full = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      cells     <= '0;
      cursor    <= '0;
      turn      <= 1'b0;
      winner    <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      frame     <= '0;
    end else begin
      state  <= state_n;
      cells  <= cells_n;
      cursor <= cursor_n;
      turn   <= turn_n;
      winner <= winner_n;
      frame  <= img;
      if (blink_cnt == CW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cells_n  = cells;
    cursor_n = cursor;
    turn_n   = turn;
    winner_n = winner;
    if (p_new) begin
      state_n  = PLAY;
      cells_n  = '0;
      cursor_n = '0;
      turn_n   = 1'b0;
      winner_n = '0;
    end else begin
      case (state)
        PLAY: begin
          // a place pulse swallows a simultaneous next even when the cell is taken
          if (p_place) begin
            if (cells[cursor] == CELL_EMPTY) begin
              cells_n[cursor] = mover;
              state_n         = CHECK;
            end
          end else if (p_next) begin
            cursor_n = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
          end
        end
        CHECK: begin
          if (|mover_mask) begin
            state_n  = WIN;
            winner_n = mover;
          end else if (full) begin
            state_n = DRAW;
          end else begin
            state_n = PLAY;
            turn_n  = ~turn;
          end
        end
        default: ;
      endcase
    end
  end

  // Cell k occupies a 2x2 pixel block at row 3*(k/3), col 3*(k%3).
  always_comb begin
    img  = '0;
    on4  = 1'b0;
    diag = 1'b0;
    for (int k = 0; k < 9; k++) begin
      int base;
      base = 24 * (k / 3) + 3 * (k % 3);
      on4  = (cells[k] == CELL_X);
      diag = (cells[k] == CELL_X) || (cells[k] == CELL_O);
      if ((state == PLAY || state == CHECK) && blink && cursor == 4'(k)) begin
        on4  = 1'b1;
        diag = 1'b1;
      end
      if (state == WIN && blink && mover_mask[k]) begin
        on4  = 1'b0;
        diag = 1'b0;
      end
      img[base]     = diag;
      img[base + 1] = on4;
      img[base + 8] = on4;
      img[base + 9] = diag;
    end
  end

  assign game_state = state;

endmodule
